// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file and its clear engine.
package regfile_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_SWEEP = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine: walks every entry once, one per cycle, then pulses done.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_strobe,
  output logic [ADDR_W-1:0] clr_idx
);

  clr_state_t        r_state;
  clr_state_t        w_state_next;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= CLR_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Terminal compare at all-ones so the index never wraps back into the array.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    clr_busy     = 1'b0;
    clr_done     = 1'b0;
    clr_strobe   = 1'b0;
    case (r_state)
      CLR_IDLE: begin
        if (clr_req) begin
          w_state_next = CLR_SWEEP;
          w_idx_next   = '0;
        end
      end
      CLR_SWEEP: begin
        clr_busy   = 1'b1;
        clr_strobe = 1'b1;
        if (r_idx == '1) begin
          w_state_next = CLR_DONE;
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end
      CLR_DONE: begin
        clr_done     = 1'b1;
        w_state_next = CLR_IDLE;
      end
      default: begin
        w_state_next = CLR_IDLE;
      end
    endcase
  end

  assign clr_idx = r_idx;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, optional bypass and zero register,
// per-entry scoreboard busy bits and a sweeping clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     sb_set_en,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic              w_clr_busy;
  logic              w_clr_done;
  logic              w_clr_strobe;
  logic [ADDR_W-1:0] w_clr_idx;
  logic              w_wr_allow;
  logic              w_wr0_ok;
  logic              w_wr1_ok;
  logic              w_sb_ok;

  regfile_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk        (clk),
    .reset      (reset),
    .clr_req    (clr_req),
    .clr_busy   (w_clr_busy),
    .clr_done   (w_clr_done),
    .clr_strobe (w_clr_strobe),
    .clr_idx    (w_clr_idx)
  );

  // Write and scoreboard ports are locked out for the whole sweep including its done cycle.
  assign w_wr_allow = ~w_clr_busy & ~w_clr_done;
  assign w_wr0_ok   = wr0_en & w_wr_allow & ~((ZERO_REG != 0) && (wr0_addr == '0));
  assign w_wr1_ok   = wr1_en & w_wr_allow & ~((ZERO_REG != 0) && (wr1_addr == '0));
  assign w_sb_ok    = sb_set_en & w_wr_allow & ~((ZERO_REG != 0) && (sb_set_addr == '0));

  // Later assignments win: wr1 over wr0 on data, a new scoreboard set over a write's clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_mem[e] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_clr_strobe) begin
        r_mem[w_clr_idx]  <= '0;
        r_busy[w_clr_idx] <= 1'b0;
      end
      if (w_wr0_ok) begin
        r_mem[wr0_addr]  <= wr0_data;
        r_busy[wr0_addr] <= 1'b0;
      end
      if (w_wr1_ok) begin
        r_mem[wr1_addr]  <= wr1_data;
        r_busy[wr1_addr] <= 1'b0;
      end
      if (w_sb_ok) begin
        r_busy[sb_set_addr] <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_zero;
      logic              w_hit0;
      logic              w_hit1;
      logic              w_sb_hit;

      assign w_addr   = rd_addr[gi*ADDR_W +: ADDR_W];
      assign w_zero   = (ZERO_REG != 0) && (w_addr == '0);
      assign w_hit0   = w_wr0_ok && (wr0_addr == w_addr);
      assign w_hit1   = w_wr1_ok && (wr1_addr == w_addr);
      assign w_sb_hit = w_sb_ok && (sb_set_addr == w_addr);

      assign rd_data[gi*DATA_W +: DATA_W] =
          w_zero                     ? '0       :
          ((BYPASS != 0) && w_hit1)  ? wr1_data :
          ((BYPASS != 0) && w_hit0)  ? wr0_data :
                                       r_mem[w_addr];

      // A retiring write hides the busy bit unless a new producer claims the same entry.
      assign rd_busy[gi] =
          w_zero     ? 1'b0 :
          w_clr_busy ? 1'b1 :
          (r_busy[w_addr] & ~((BYPASS != 0) & (w_hit0 | w_hit1) & ~w_sb_hit));
    end
  endgenerate

  assign clr_busy = w_clr_busy;
  assign clr_done = w_clr_done;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp against a cycle-level behavioural model of the register file.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr0_en = 1'b0;
  logic [4:0]  wr0_addr = '0;
  logic [31:0] wr0_data = '0;
  logic        wr1_en = 1'b0;
  logic [4:0]  wr1_addr = '0;
  logic [31:0] wr1_data = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        sb_set_en = 1'b0;
  logic [4:0]  sb_set_addr = '0;
  logic        clr_req = 1'b0;
  logic        clr_busy;
  logic        clr_done;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Model: m_pos = -1 idle, 0..31 entry being swept this cycle, 32 done cycle.
  logic [31:0] m_mem [32] = '{default: 32'h0};
  bit          m_busy [32] = '{default: 1'b0};
  int          m_pos = -1;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .reset(reset),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < 32; e++) begin
        m_mem[e]  <= 32'h0;
        m_busy[e] <= 1'b0;
      end
      m_pos <= -1;
    end else if (m_pos >= 0 && m_pos < 32) begin
      m_mem[m_pos]  <= 32'h0;
      m_busy[m_pos] <= 1'b0;
      m_pos <= m_pos + 1;
    end else if (m_pos == 32) begin
      m_pos <= -1;
    end else begin
      if (clr_req) m_pos <= 0;
      if (wr0_en && wr0_addr != 0) begin
        m_mem[wr0_addr]  <= wr0_data;
        m_busy[wr0_addr] <= 1'b0;
      end
      if (wr1_en && wr1_addr != 0) begin
        m_mem[wr1_addr]  <= wr1_data;
        m_busy[wr1_addr] <= 1'b0;
      end
      if (sb_set_en && sb_set_addr != 0) m_busy[sb_set_addr] <= 1'b1;
    end
  end

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    bit allow = (m_pos == -1);
    if (a == 0) return 32'h0;
    if (allow && wr1_en && wr1_addr == a) return wr1_data;
    if (allow && wr0_en && wr0_addr == a) return wr0_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    bit allow = (m_pos == -1);
    bit hit;
    bit sb;
    if (a == 0) return 1'b0;
    if (m_pos >= 0 && m_pos < 32) return 1'b1;
    hit = allow && ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a));
    sb  = allow && sb_set_en && sb_set_addr == a;
    return m_busy[a] && !(hit && !sb);
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      for (int p = 0; p < 2; p++) begin
        logic [4:0] a;
        a = rd_addr[p*5 +: 5];
        chk($sformatf("rd_data%0d a%0d", p, a), {32'h0, rd_data[p*32 +: 32]}, {32'h0, exp_data(a)});
        chk($sformatf("rd_busy%0d a%0d", p, a), {63'h0, rd_busy[p]}, {63'h0, exp_busy(a)});
      end
      chk("clr_busy", {63'h0, clr_busy}, {63'h0, (m_pos >= 0 && m_pos < 32)});
      chk("clr_done", {63'h0, clr_done}, {63'h0, (m_pos == 32)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr0_en = 1'b0; wr1_en = 1'b0; sb_set_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int n_busy;
    int cyc;
    int done_cyc;
    int n_done;
    #2 reset = 1'b1;
    chk_on = 1'b1;

    // Reset: every address reads zero, not busy.
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(31 - i), 5'(i)};
      at_neg();
      chk("reset_rd0", {32'h0, rd_data[31:0]}, 64'h0);
      chk("reset_busy", {62'h0, rd_busy}, 64'h0);
      step();
    end
    reset = 1'b0;
    step();

    // Dual write same address: wr1 wins, bypassed before the edge.
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'h11111111;
    wr1_en = 1; wr1_addr = 5; wr1_data = 32'h22222222;
    rd_addr = {5'd5, 5'd5};
    at_neg();
    chk("bypass_a5", {32'h0, rd_data[31:0]}, 64'h22222222);
    step();
    idle_inputs();
    at_neg();
    chk("stored_a5", {32'h0, rd_data[63:32]}, 64'h22222222);
    step();

    // Zero register ignores write and scoreboard.
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hDEADBEEF;
    sb_set_en = 1; sb_set_addr = 0; rd_addr = {5'd0, 5'd0};
    step();
    idle_inputs();
    at_neg();
    chk("zero_data", {32'h0, rd_data[31:0]}, 64'h0);
    chk("zero_busy", {63'h0, rd_busy[0]}, 64'h0);
    step();

    // Scoreboard set, bypass-hidden busy, set+write keeps busy.
    sb_set_en = 1; sb_set_addr = 7; rd_addr = {5'd7, 5'd7};
    step();
    idle_inputs();
    at_neg();
    chk("sb_a7_busy", {63'h0, rd_busy[0]}, 64'h1);
    step();
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h7;
    at_neg();
    chk("wb_a7_busy", {63'h0, rd_busy[0]}, 64'h0);
    chk("wb_a7_data", {32'h0, rd_data[31:0]}, 64'h7);
    step();
    wr0_data = 32'h8; sb_set_en = 1; sb_set_addr = 7;
    step();
    idle_inputs();
    at_neg();
    chk("setwr_a7_busy", {63'h0, rd_busy[1]}, 64'h1);
    step();

    // Fill, sweep, dropped write during sweep.
    for (int i = 0; i < 32; i++) begin
      wr0_en = 1; wr0_addr = 5'(i); wr0_data = 32'h01010101 * i + 1;
      step();
    end
    idle_inputs();
    clr_req = 1;
    step();
    clr_req = 0;
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'h3; rd_addr = {5'd3, 5'd3};
    n_busy = 0; cyc = 0; done_cyc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      cyc++;
      if (clr_done) begin done_cyc = cyc; break; end
      if (clr_busy) n_busy++;
      step();
    end
    chk("sweep_len", 64'(n_busy), 64'd32);
    chk("done_cycle", 64'(done_cyc), 64'd33);
    step();
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(i), 5'(i)};
      at_neg();
      chk("post_clr_rd", {32'h0, rd_data[31:0]}, 64'h0);
      step();
    end

    // Reset at sweep index 10.
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'h99;
    wr1_en = 1; wr1_addr = 20; wr1_data = 32'h20;
    step();
    idle_inputs();
    clr_req = 1;
    step();
    clr_req = 0;
    repeat (10) step();
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", {63'h0, clr_busy}, 64'h0);
    rd_addr = {5'd20, 5'd9};
    #1;
    chk("rst_mid_a9", {32'h0, rd_data[31:0]}, 64'h0);
    chk("rst_mid_a20", {32'h0, rd_data[63:32]}, 64'h0);
    step();
    step();
    reset = 1'b0;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (clr_done) n_done++;
      step();
    end
    chk("no_done_after_rst", 64'(n_done), 64'h0);

    // Random traffic with small-address bias to provoke collisions.
    for (int k = 0; k < 2500; k++) begin
      wr0_en = 1'($urandom_range(0, 1));
      wr0_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wr0_data = $urandom;
      wr1_en = 1'($urandom_range(0, 2) == 0);
      wr1_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wr1_data = $urandom;
      sb_set_en = 1'($urandom_range(0, 2) == 0);
      sb_set_addr = 5'($urandom_range(0, 7));
      rd_addr = {5'($urandom_range(0, 7)), 5'($urandom)};
      clr_req = 1'($urandom_range(0, 199) == 0);
      step();
    end
    idle_inputs();
    step();
    chk_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
